// File: rtl/aux_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : aux_uart_tx
// Purpose  : 8N1 byte UART transmitter (LSB first) fed by a small input FIFO.
// Revision : 1.0
// ============================================================================
module aux_uart_tx #(
    parameter int CLK_FREQUENCY = 50000000,
    parameter int BAUD_RATE     = 115200,
    parameter int FIFO_DEPTH    = 4,
    parameter int STOP_BITS     = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_CLKS_PER_BIT = CLK_FREQUENCY / BAUD_RATE;
    localparam int c_PTR_W        = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W        = c_PTR_W + 1;
    localparam int c_BAUD_W       = $clog2(STOP_BITS * c_CLKS_PER_BIT);

    localparam logic [c_BAUD_W-1:0] c_BIT_LAST  = c_BAUD_W'(c_CLKS_PER_BIT - 1);
    localparam logic [c_BAUD_W-1:0] c_STOP_LAST = c_BAUD_W'(STOP_BITS * c_CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0]  c_FULL      = c_CNT_W'(FIFO_DEPTH);

    generate
        if (c_CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("aux_uart_tx: CLK_FREQUENCY / BAUD_RATE must be at least 2");
        end
        if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
            $error("aux_uart_tx: STOP_BITS must be 1 or 2");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("aux_uart_tx: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    state_t              r_state;
    logic                r_tx;
    logic [7:0]          r_shift;
    logic [2:0]          r_bit;
    logic [c_BAUD_W-1:0] r_baud;

    logic w_push;
    logic w_pop;
    logic w_nonempty;
    logic w_bit_last;
    logic w_stop_last;

    // No pass-through when full: a same-cycle pop does not free a slot early.
    assign tx_ready    = (r_count != c_FULL);
    assign w_push      = tx_valid && tx_ready;
    assign w_nonempty  = (r_count != '0);
    assign w_bit_last  = (r_baud == c_BIT_LAST);
    assign w_stop_last = (r_baud == c_STOP_LAST);
    assign w_pop       = w_nonempty &&
                         ((r_state == S_IDLE) || ((r_state == S_STOP) && w_stop_last));

    assign tx         = r_tx;
    assign busy       = (r_state != S_IDLE) || w_nonempty;
    assign fifo_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_shift <= '0;
            r_bit   <= '0;
            r_baud  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_tx    <= 1'b0;
                        r_baud  <= '0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_last) begin
                        r_tx    <= r_shift[0];
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_last) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            // Bit 1 of the shifter is the next bit on the line.
                            r_tx    <= r_shift[1];
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_stop_last) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= r_mem[r_rd_ptr];
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
